spm_seq: RTL

//  Parametrised serial-parallel multiplier. Successor to the fixed 32-bit spm core.

---
 rtl/spm_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/spm_seq.sv
// Serial-parallel multiplier: WIDTH carry-save cells fed LSB-first by the serial operand,
// one product bit per cycle into p, with operand/result valid-ready handshakes.
module spm_seq #(
  parameter int WIDTH = 8,
  parameter int TC_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic                 tc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int CW = $clog2(2 * WIDTH);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high.
  // in_ready depends on state and out_ready only, never on in_valid.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_live;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic               r_tc;
  logic [WIDTH-1:0]   r_h;
  logic [WIDTH-1:0]   r_c;
  logic               r_he;
  logic               r_ce;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_p;

  logic               w_accept;
  logic               w_last;
  logic               w_yb;
  logic               w_s;
  logic [WIDTH-1:0]   w_term;
  logic [WIDTH-1:0]   w_up;
  logic [WIDTH-1:0]   w_h_nxt;
  logic [WIDTH-1:0]   w_c_nxt;
  logic               w_he_nxt;
  logic               w_ce_nxt;

  assign in_ready  = r_live && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_state == S_RUN) && (r_cnt == CW'(2 * WIDTH - 1));
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_RUN);
  assign p         = r_p;
  assign dbg_state = r_state;

  // The extra sign cell (r_he/r_ce) stands for every bit position above the MSB cell;
  // those positions all hold identical values, so one cell feeding itself covers them.
  assign w_yb     = r_y[0];
  assign w_s      = r_tc & r_x[WIDTH-1] & w_yb;
  assign w_term   = r_x & {WIDTH{w_yb}};
  assign w_up     = {r_he, r_h[WIDTH-1:1]};
  assign w_h_nxt  = w_term ^ w_up ^ r_c;
  assign w_c_nxt  = (w_term & w_up) | (w_term & r_c) | (w_up & r_c);
  assign w_he_nxt = w_s ^ r_he ^ r_ce;
  assign w_ce_nxt = (w_s & r_he) | (w_s & r_ce) | (r_he & r_ce);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_RUN;
      S_RUN:  if (w_last) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = w_accept ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
      r_tc   <= 1'b0;
      r_h    <= '0;
      r_c    <= '0;
      r_he   <= 1'b0;
      r_ce   <= 1'b0;
      r_cnt  <= '0;
      r_p    <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_x   <= x;
        r_y   <= y;
        r_tc  <= (TC_EN != 0) && tc;
        r_h   <= '0;
        r_c   <= '0;
        r_he  <= 1'b0;
        r_ce  <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_h   <= w_h_nxt;
        r_c   <= w_c_nxt;
        r_he  <= w_he_nxt;
        r_ce  <= w_ce_nxt;
        // Arithmetic shift keeps feeding the sign bit once y is exhausted in signed mode.
        r_y   <= {r_tc & r_y[WIDTH-1], r_y[WIDTH-1:1]};
        r_p   <= {w_h_nxt[0], r_p[2*WIDTH-1:1]};
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule
